// File: rtl/multiplexer.sv
// ---------------------------------------------------------------------------
// multiplexer
//
// Selects between functional data and BIST-controller data on its way to the
// memory. It also tracks which mode is active, pulses on each mode change and
// keeps a saturating count of those changes.
//
// Parameters
//   WIDTH    data width of normal_in / bist_in / out (1..1024)
//   REG_OUT  0 = combinational data path, 1 = registered data path
//
// Ports
//   clk           rising-edge clock for all state
//   rst           synchronous active-high reset
//   Nbart         mode select: 0 = normal, 1 = BIST
//   normal_in     functional-path data
//   bist_in       BIST-controller data
//   out           selected data toward the memory
//   bist_active   registered copy of Nbart
//   mode_switch   one-cycle pulse on each registered mode change
//   switch_count  saturating (at 255) count of mode changes since reset
// ---------------------------------------------------------------------------
module multiplexer #(
    parameter int unsigned WIDTH   = 10,
    parameter int unsigned REG_OUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Nbart,
    input  logic [WIDTH-1:0] normal_in,
    input  logic [WIDTH-1:0] bist_in,
    output logic [WIDTH-1:0] out,
    output logic             bist_active,
    output logic             mode_switch,
    output logic [7:0]       switch_count
);

    logic [WIDTH-1:0] sel_data;

    always_comb begin
        sel_data = normal_in;
        if (Nbart) begin
            sel_data = bist_in;
        end
    end

    // Only the registered variant sees reset; the combinational path keeps
    // following its inputs even while rst is high.
    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [WIDTH-1:0] out_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_q <= '0;
                end else begin
                    out_q <= sel_data;
                end
            end

            assign out = out_q;
        end else begin : g_comb_out
            assign out = sel_data;
        end
    endgenerate

    // A change is detected by comparing the incoming select against the
    // value captured on the previous edge, so the pulse lines up with the
    // edge on which bist_active takes its new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            bist_active  <= 1'b0;
            mode_switch  <= 1'b0;
            switch_count <= '0;
        end else begin
            bist_active <= Nbart;
            mode_switch <= Nbart ^ bist_active;
            if (mode_switch && (switch_count != 8'hFF)) begin
                switch_count <= switch_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_multiplexer.sv
// ---------------------------------------------------------------------------
// tb_multiplexer
//
// Directed bench for multiplexer. Six instances share clk/rst/Nbart:
//   index 0: WIDTH=10 comb    index 1: WIDTH=10 registered
//   index 2: WIDTH=1  comb    index 3: WIDTH=1  registered
//   index 4: WIDTH=64 comb    index 5: WIDTH=64 registered
// Status outputs are checked on the WIDTH=10 instances.
// ---------------------------------------------------------------------------
module tb_multiplexer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic nbart = 1'b0;

    logic [9:0]  n10 = '0, b10 = '0;
    logic [0:0]  n1  = '0, b1  = '0;
    logic [63:0] n64 = '0, b64 = '0;

    logic [9:0]  o10c, o10r;
    logic [0:0]  o1c, o1r;
    logic [63:0] o64c, o64r;

    logic [5:0] ba_v, ms_v;
    logic [7:0] sc_v [6];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multiplexer #(.WIDTH(10), .REG_OUT(0)) u_w10_comb (
        .clk(clk), .rst(rst), .Nbart(nbart), .normal_in(n10), .bist_in(b10), .out(o10c),
        .bist_active(ba_v[0]), .mode_switch(ms_v[0]), .switch_count(sc_v[0]));
    multiplexer #(.WIDTH(10), .REG_OUT(1)) u_w10_reg (
        .clk(clk), .rst(rst), .Nbart(nbart), .normal_in(n10), .bist_in(b10), .out(o10r),
        .bist_active(ba_v[1]), .mode_switch(ms_v[1]), .switch_count(sc_v[1]));
    multiplexer #(.WIDTH(1), .REG_OUT(0)) u_w1_comb (
        .clk(clk), .rst(rst), .Nbart(nbart), .normal_in(n1), .bist_in(b1), .out(o1c),
        .bist_active(ba_v[2]), .mode_switch(ms_v[2]), .switch_count(sc_v[2]));
    multiplexer #(.WIDTH(1), .REG_OUT(1)) u_w1_reg (
        .clk(clk), .rst(rst), .Nbart(nbart), .normal_in(n1), .bist_in(b1), .out(o1r),
        .bist_active(ba_v[3]), .mode_switch(ms_v[3]), .switch_count(sc_v[3]));
    multiplexer #(.WIDTH(64), .REG_OUT(0)) u_w64_comb (
        .clk(clk), .rst(rst), .Nbart(nbart), .normal_in(n64), .bist_in(b64), .out(o64c),
        .bist_active(ba_v[4]), .mode_switch(ms_v[4]), .switch_count(sc_v[4]));
    multiplexer #(.WIDTH(64), .REG_OUT(1)) u_w64_reg (
        .clk(clk), .rst(rst), .Nbart(nbart), .normal_in(n64), .bist_in(b64), .out(o64r),
        .bist_active(ba_v[5]), .mode_switch(ms_v[5]), .switch_count(sc_v[5]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic ba, input logic ms,
                                input logic [7:0] sc);
        check({tag, ".bist_active"}, {63'd0, ba_v[1]}, {63'd0, ba});
        check({tag, ".mode_switch"}, {63'd0, ms_v[1]}, {63'd0, ms});
        check({tag, ".switch_count"}, {56'd0, sc_v[1]}, {56'd0, sc});
    endtask

    initial begin
        logic [9:0]  e10;
        logic [0:0]  e1;
        logic [63:0] e64;

        // Combinational path before any clock edge, with rst held high.
        #1;
        check("comb_zero_nb0", {54'd0, o10c}, 64'h0);
        nbart = 1'b1;
        #1;
        check("comb_zero_nb1", {54'd0, o10c}, 64'h0);
        n10 = 10'h155;
        b10 = 10'h2AA;
        nbart = 1'b0;
        #1;
        check("comb_normal_155", {54'd0, o10c}, 64'h155);
        nbart = 1'b1;
        #1;
        check("comb_bist_2aa", {54'd0, o10c}, 64'h2AA);

        // First edge with rst=1 and Nbart=1: reset wins over every update.
        @(posedge clk); #1;
        check("reg_reset_out", {54'd0, o10r}, 64'h0);
        check_status("reset", 1'b0, 1'b0, 8'd0);

        // Release reset with BIST selected: output appears one edge later.
        @(negedge clk);
        rst = 1'b0;
        nbart = 1'b1;
        b10 = 10'h3FF;
        #1;
        check("reg_not_before_edge", {54'd0, o10r}, 64'h0);
        check("comb_3ff_immediate", {54'd0, o10c}, 64'h3FF);
        @(posedge clk); #1;
        check("reg_3ff_after_edge", {54'd0, o10r}, 64'h3FF);
        check_status("release_nb1", 1'b1, 1'b1, 8'd0);
        @(posedge clk); #1;
        check_status("release_next", 1'b1, 1'b0, 8'd1);

        // Clean reset, then a single rising Nbart at edge N.
        @(negedge clk);
        rst = 1'b1;
        nbart = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_status("idle_normal", 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        nbart = 1'b1;
        @(posedge clk); #1;
        check_status("edge_n", 1'b1, 1'b1, 8'd0);
        @(posedge clk); #1;
        check_status("edge_n1", 1'b1, 1'b0, 8'd1);
        @(posedge clk); #1;
        check_status("edge_n2_hold", 1'b1, 1'b0, 8'd1);

        // Toggle every cycle for 300 cycles: count 1 + 299 saturates at 255.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            nbart = ~nbart;
            @(posedge clk); #1;
            if (i == 9) begin
                check("toggle_count_10", {56'd0, sc_v[1]}, 64'd10);
            end
        end
        check("toggle_pulse_high", {63'd0, ms_v[1]}, 64'd1);
        check("toggle_saturate", {56'd0, sc_v[1]}, 64'd255);
        check("toggle_saturate_w10c", {56'd0, sc_v[0]}, 64'd255);
        @(posedge clk); #1;
        check("toggle_saturate_hold", {56'd0, sc_v[1]}, 64'd255);

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_status("after_sat_reset", 1'b0, 1'b0, 8'd0);

        // Random data across widths, both data-path variants.
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            nbart = 1'($urandom_range(0, 1));
            n10 = 10'($urandom);
            b10 = 10'($urandom);
            n1  = 1'($urandom);
            b1  = 1'($urandom);
            n64 = {$urandom, $urandom};
            b64 = {$urandom, $urandom};
            e10 = nbart ? b10 : n10;
            e1  = nbart ? b1 : n1;
            e64 = nbart ? b64 : n64;
            #1;
            check("rand_w10_comb", {54'd0, o10c}, {54'd0, e10});
            check("rand_w1_comb", {63'd0, o1c}, {63'd0, e1});
            check("rand_w64_comb", o64c, e64);
            @(posedge clk); #1;
            check("rand_w10_reg", {54'd0, o10r}, {54'd0, e10});
            check("rand_w1_reg", {63'd0, o1r}, {63'd0, e1});
            check("rand_w64_reg", o64r, e64);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
